// File: rtl/cs161_ctrl_pkg.sv
// Shared encodings for the cs161 multi-cycle control path: opcodes, funct codes,
// ALU operations, FSM state codes and datapath mux select codes.
package cs161_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_START     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_RD    = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WR    = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12,
    S_ILLEGAL   = 4'd13
  } state_t;

endpackage

// File: rtl/cs161_alu_decode.sv
// R-type funct field to ALU operation; funct_valid flags the six supported functs.
module cs161_alu_decode
  import cs161_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       funct_valid
);

  always_comb begin
    alu_op      = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_NOR:  alu_op = ALU_NOR;
      FN_SLT:  alu_op = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/cs161_mc_control.sv
// Multi-cycle MIPS control FSM with retired-instruction counter and sticky illegal flag.
// Optional CS161_MEM_HANDSHAKE_EN: FETCH/MEM_RD/MEM_WR wait for mem_ready.
module cs161_mc_control
  import cs161_ctrl_pkg::*;
#(
  parameter int COUNT_W      = 32,
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         instr_op,
  input  logic [5:0]         funct,
  input  logic               alu_zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [3:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] instr_count,
  output logic               illegal
);

  state_t             state_q, state_d;
  logic               is_store_q;
  logic [COUNT_W-1:0] count_q;
  logic               illegal_q;
  logic [3:0]         dec_alu_op;
  logic               dec_funct_valid;
  logic               mem_done;
  logic               retire;
  logic               alu_zero_unused;

`ifdef CS161_MEM_HANDSHAKE_EN
  assign mem_done = mem_ready;
`else
  // mem_ready has no effect in this build; every memory state lasts one cycle
  assign mem_done = 1'b1 | mem_ready;
`endif

  // alu_zero qualifies pc_write_cond in the datapath, not the sequencing here
  assign alu_zero_unused = alu_zero;

  cs161_alu_decode u_alu_decode (
    .funct       (funct),
    .alu_op      (dec_alu_op),
    .funct_valid (dec_funct_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_START;
      is_store_q <= 1'b0;
      count_q    <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE)
        is_store_q <= (instr_op == OP_SW);
      if (retire)
        count_q <= count_q + COUNT_W'(1);
      if (state_d == S_ILLEGAL)
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = S_START;
    case (state_q)
      S_START:  state_d = S_FETCH;
      S_FETCH:  state_d = mem_done ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (instr_op)
          OP_RTYPE:     state_d = dec_funct_valid ? S_R_EXEC : S_ILLEGAL;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR:  state_d = is_store_q ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:    state_d = mem_done ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WR:    state_d = mem_done ? S_FETCH : S_MEM_WR;
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_ADDI_WB:   state_d = S_FETCH;
      S_ILLEGAL:   state_d = ILLEGAL_HALT ? S_ILLEGAL : S_FETCH;
      default:     state_d = S_START;
    endcase
  end

  // An instruction retires on the edge that leaves its final state
  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: retire = 1'b1;
      S_MEM_WR: retire = mem_done;
      default:  retire = 1'b0;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_op        = ALU_AND;
    pc_source     = PCSRC_ALU;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = mem_done;
        pc_write  = mem_done;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        alu_op    = ALU_ADD;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = dec_alu_op;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      S_ADDI_WB: reg_write = 1'b1;
      default: ;
    endcase
  end

  assign state       = state_q;
  assign instr_count = count_q;
  assign illegal     = illegal_q;

endmodule
